// File: rtl/cpu_seq_ctrl_if.sv
// Instruction fetch port between the sequencer and instruction memory.
// The sequencer holds instr_req and instr_addr stable until memory acknowledges.
interface cpu_seq_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             instr_req;
    logic [WIDTH-1:0] instr_addr;
    logic             instr_ack;
    logic [WIDTH-1:0] instr_data;

    modport master (
        output instr_req,
        output instr_addr,
        input  instr_ack,
        input  instr_data
    );

    modport slave (
        input  instr_req,
        input  instr_addr,
        output instr_ack,
        output instr_data
    );
endinterface

// File: rtl/cpu_seq_ctrl.sv
// Multicycle sequencer: fetch, decode, execute, writeback, with an absorbing halt.
// Owns the program counter and instruction register; register-file controls are decoded from IR.
module cpu_seq_ctrl #(
    parameter int WIDTH   = 16,
    parameter int REGBITS = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    cpu_seq_ctrl_if.master      fetch,
    output logic [3:0]          opcode,
    output logic [3:0]          opext,
    output logic [REGBITS-1:0]  ra1,
    output logic [REGBITS-1:0]  ra2,
    output logic [REGBITS-1:0]  wa,
    output logic                regwrite,
    output logic                alu_src_imm,
    output logic [WIDTH-1:0]    imm,
    output logic                halted
);

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_WRITEBACK = 3'd3,
        S_HALT      = 3'd4
    } state_t;

    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_CMP   = 4'b1011;
    localparam logic [3:0] OP_HALT  = 4'b1111;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  pc_q, pc_d;
    logic [WIDTH-1:0]  ir_q, ir_d;
    logic              req_q, req_d;
    logic              regwrite_q, regwrite_d;
    logic              halted_q, halted_d;

    // Compares only set flags, so they skip the register write.
    function automatic logic is_compare(input logic [WIDTH-1:0] ir);
        logic cmp;
        if (ir[15:12] == OP_CMP) begin
            cmp = 1'b1;
        end else if ((ir[15:12] == OP_RTYPE) && (ir[7:4] == OP_CMP)) begin
            cmp = 1'b1;
        end else begin
            cmp = 1'b0;
        end
        return cmp;
    endfunction

    function automatic logic is_immediate(input logic [WIDTH-1:0] ir);
        logic im;
        if ((ir[15:12] == OP_RTYPE) || (ir[15:12] == OP_HALT)) begin
            im = 1'b0;
        end else begin
            im = 1'b1;
        end
        return im;
    endfunction

    // State, PC, IR and registered strobes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_FETCH;
            pc_q       <= {WIDTH{1'b0}};
            ir_q       <= {WIDTH{1'b0}};
            req_q      <= 1'b0;
            regwrite_q <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            req_q      <= req_d;
            regwrite_q <= regwrite_d;
            halted_q   <= halted_d;
        end
    end

    // Next-state logic; a fetch is accepted only once the request is visible on the port.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        case (state_q)
            S_FETCH: begin
                if (req_q && fetch.instr_ack) begin
                    ir_d    = fetch.instr_data;
                    pc_d    = pc_q + {{(WIDTH-1){1'b0}}, 1'b1};
                    state_d = S_DECODE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                if (ir_q[15:12] == OP_HALT) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_EXECUTE;
                end
            end
            S_EXECUTE:   state_d = S_WRITEBACK;
            S_WRITEBACK: state_d = S_FETCH;
            S_HALT:      state_d = S_HALT;
            default:     state_d = S_FETCH;
        endcase

        req_d      = (state_d == S_FETCH);
        regwrite_d = (state_d == S_WRITEBACK) && !is_compare(ir_q);
        halted_d   = (state_d == S_HALT);
    end

    // Field decode from IR; stable from DECODE through WRITEBACK.
    always_comb begin
        opcode      = ir_q[15:12];
        ra1         = ir_q[8 +: REGBITS];
        ra2         = ir_q[0 +: REGBITS];
        wa          = ir_q[8 +: REGBITS];
        imm         = {{(WIDTH-8){ir_q[7]}}, ir_q[7:0]};
        alu_src_imm = is_immediate(ir_q);
        if (ir_q[15:12] == OP_RTYPE) begin
            opext = ir_q[7:4];
        end else begin
            opext = 4'b0000;
        end
    end

    assign fetch.instr_req  = req_q;
    assign fetch.instr_addr = pc_q;
    assign regwrite         = regwrite_q;
    assign halted           = halted_q;

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Directed bench for cpu_seq_ctrl: a vector table of instructions plus hand-written
// sequences for PC wrap, halt, and reset during writeback / halt.
module tb_cpu_seq_ctrl;

    logic        clk;
    logic        reset_n;
    logic [3:0]  opcode, opext;
    logic [3:0]  ra1, ra2, wa;
    logic        regwrite, alu_src_imm, halted;
    logic [15:0] imm;

    int          n_checks;
    int          n_fail;
    logic [15:0] pc_model;

    cpu_seq_ctrl_if #(.WIDTH(16)) bus ();

    cpu_seq_ctrl #(.WIDTH(16), .REGBITS(4)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .fetch       (bus.master),
        .opcode      (opcode),
        .opext       (opext),
        .ra1         (ra1),
        .ra2         (ra2),
        .wa          (wa),
        .regwrite    (regwrite),
        .alu_src_imm (alu_src_imm),
        .imm         (imm),
        .halted      (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] instr;
        int          waits;
        logic        spur;
        logic [3:0]  op;
        logic [3:0]  ext;
        logic [3:0]  r1;
        logic [3:0]  r2;
        logic [3:0]  w;
        logic [15:0] imm;
        logic        src;
        logic        rw;
    } vec_t;

    vec_t vecs [7];
    vec_t halt_vec;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_fields(input vec_t v);
        chk("opcode", {28'd0, opcode}, {28'd0, v.op});
        chk("opext", {28'd0, opext}, {28'd0, v.ext});
        chk("ra1", {28'd0, ra1}, {28'd0, v.r1});
        chk("ra2", {28'd0, ra2}, {28'd0, v.r2});
        chk("wa", {28'd0, wa}, {28'd0, v.w});
        chk("imm", {16'd0, imm}, {16'd0, v.imm});
        chk("alu_src_imm", {31'd0, alu_src_imm}, {31'd0, v.src});
    endtask

    task automatic wait_req();
        int cnt;
        cnt = 0;
        while (bus.instr_req !== 1'b1 && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        chk("fetch_req", {31'd0, bus.instr_req}, 32'd1);
    endtask

    // Full instruction from FETCH to the next FETCH (or into HALT).
    task automatic run_instr(input vec_t v);
        wait_req();
        chk("fetch_addr", {16'd0, bus.instr_addr}, {16'd0, pc_model});
        for (int i = 0; i < v.waits; i++) begin
            @(negedge clk);
            chk("wait_req", {31'd0, bus.instr_req}, 32'd1);
            chk("wait_addr", {16'd0, bus.instr_addr}, {16'd0, pc_model});
        end
        bus.instr_ack  = 1'b1;
        bus.instr_data = v.instr;
        @(negedge clk);
        bus.instr_ack  = 1'b0;
        bus.instr_data = 16'hF0F0;
        pc_model       = pc_model + 16'd1;
        chk("decode_req", {31'd0, bus.instr_req}, 32'd0);
        chk("decode_rw", {31'd0, regwrite}, 32'd0);
        chk_fields(v);
        @(negedge clk);
        if (v.instr[15:12] == 4'hF) begin
            chk("halt_halted", {31'd0, halted}, 32'd1);
            chk("halt_req", {31'd0, bus.instr_req}, 32'd0);
        end else begin
            chk("exec_rw", {31'd0, regwrite}, 32'd0);
            chk("exec_halted", {31'd0, halted}, 32'd0);
            if (v.spur) begin
                bus.instr_ack  = 1'b1;
                bus.instr_data = 16'hF000;
            end else begin
                bus.instr_ack  = 1'b0;
            end
            @(negedge clk);
            bus.instr_ack = 1'b0;
            chk("wb_rw", {31'd0, regwrite}, {31'd0, v.rw});
            chk("wb_req", {31'd0, bus.instr_req}, 32'd0);
            chk_fields(v);
            @(negedge clk);
            chk("next_rw", {31'd0, regwrite}, 32'd0);
            chk("next_req", {31'd0, bus.instr_req}, 32'd1);
            chk("next_addr", {16'd0, bus.instr_addr}, {16'd0, pc_model});
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        pc_model = 16'd0;
        //             instr     wt sp  op    ext   r1    r2    w     imm       src   rw
        vecs[0] = '{16'h0125, 0, 1'b0, 4'h0, 4'h2, 4'h1, 4'h5, 4'h1, 16'h0025, 1'b0, 1'b1};
        vecs[1] = '{16'h53F0, 0, 1'b0, 4'h5, 4'h0, 4'h3, 4'h0, 4'h3, 16'hFFF0, 1'b1, 1'b1};
        vecs[2] = '{16'h5307, 0, 1'b0, 4'h5, 4'h0, 4'h3, 4'h7, 4'h3, 16'h0007, 1'b1, 1'b1};
        vecs[3] = '{16'hB204, 0, 1'b0, 4'hB, 4'h0, 4'h2, 4'h4, 4'h2, 16'h0004, 1'b1, 1'b0};
        vecs[4] = '{16'h02B4, 0, 1'b0, 4'h0, 4'hB, 4'h2, 4'h4, 4'h2, 16'hFFB4, 1'b0, 1'b0};
        vecs[5] = '{16'h1A9C, 3, 1'b1, 4'h1, 4'h0, 4'hA, 4'hC, 4'hA, 16'hFF9C, 1'b1, 1'b1};
        vecs[6] = '{16'h0B3B, 1, 1'b0, 4'h0, 4'h3, 4'hB, 4'hB, 4'hB, 16'h003B, 1'b0, 1'b1};
        halt_vec = '{16'hF000, 0, 1'b0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0000, 1'b0, 1'b0};

        bus.instr_ack  = 1'b0;
        bus.instr_data = 16'h0000;
        reset_n        = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_req", {31'd0, bus.instr_req}, 32'd0);
        chk("rst_addr", {16'd0, bus.instr_addr}, 32'd0);
        chk("rst_rw", {31'd0, regwrite}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk_fields('{16'h0000, 0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0000, 1'b0, 1'b0});

        reset_n = 1'b1;
        #1;
        chk("release_req_low", {31'd0, bus.instr_req}, 32'd0);
        @(negedge clk);
        chk("release_req_high", {31'd0, bus.instr_req}, 32'd1);

        for (int i = 0; i < 7; i++) begin
            run_instr(vecs[i]);
        end

        // PC wrap: preload FFFF, next fetch must come from 0.
        force dut.pc_q = 16'hFFFF;
        #1;
        chk("force_addr", {16'd0, bus.instr_addr}, 32'h0000FFFF);
        release dut.pc_q;
        pc_model = 16'hFFFF;
        run_instr(vecs[0]);
        chk("wrap_addr", {16'd0, bus.instr_addr}, 32'd0);
        run_instr(vecs[2]);

        // Halt: absorbing, acks ignored, reset clears halted asynchronously.
        run_instr(halt_vec);
        for (int i = 0; i < 5; i++) begin
            bus.instr_ack  = 1'b1;
            bus.instr_data = 16'h0125;
            @(negedge clk);
            chk("halt_hold", {31'd0, halted}, 32'd1);
            chk("halt_noreq", {31'd0, bus.instr_req}, 32'd0);
        end
        bus.instr_ack = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        chk("halt_rst_halted", {31'd0, halted}, 32'd0);
        @(negedge clk);
        reset_n  = 1'b1;
        pc_model = 16'd0;

        // Reset during writeback: strobes drop at once and fetch restarts at 0.
        wait_req();
        chk("wb_run_addr", {16'd0, bus.instr_addr}, 32'd0);
        bus.instr_ack  = 1'b1;
        bus.instr_data = 16'h0125;
        @(negedge clk);
        bus.instr_ack  = 1'b0;
        repeat (2) @(negedge clk);
        chk("wb_run_rw", {31'd0, regwrite}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("wb_rst_rw", {31'd0, regwrite}, 32'd0);
        chk("wb_rst_req", {31'd0, bus.instr_req}, 32'd0);
        chk("wb_rst_halted", {31'd0, halted}, 32'd0);
        chk("wb_rst_opcode", {28'd0, opcode}, 32'd0);
        @(negedge clk);
        reset_n  = 1'b1;
        pc_model = 16'd0;
        run_instr(vecs[1]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
